// File: rtl/pipe_chain.sv
// rtl/pipe_chain.sv - chain of valid/ready register slices with flush and occupancy count
module pipe_chain #(
    parameter int  DATA_WIDTH = 32,
    parameter int  STAGES     = 4,
    parameter int  SKID       = 1,
    localparam int CAP        = STAGES * ((SKID != 0) ? 2 : 1),
    localparam int OCC_W      = $clog2(CAP + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [OCC_W-1:0]      occupancy,
    output logic                  busy
);

    logic [STAGES-1:0]     main_valid_q, main_valid_d;
    logic [STAGES-1:0]     skid_valid_q, skid_valid_d;
    logic [STAGES-1:0]     ready_q, ready_d;
    logic [DATA_WIDTH-1:0] main_data_q [STAGES];
    logic [DATA_WIDTH-1:0] main_data_d [STAGES];
    logic [DATA_WIDTH-1:0] skid_data_q [STAGES];
    logic [DATA_WIDTH-1:0] skid_data_d [STAGES];
    logic [OCC_W-1:0]      occ_q, occ_d;

    // Index i of these is the handshake entering slice i; index STAGES is the chain output.
    logic [STAGES:0]       vld_c;
    logic [STAGES:0]       rdy_c;
    logic [DATA_WIDTH-1:0] dat_c [STAGES+1];
    logic                  up_fire;
    logic                  in_fire, out_fire;

    assign vld_c = {main_valid_q, in_valid};

    always_comb begin
        dat_c[0] = in_data;
        for (int i = 0; i < STAGES; i++) begin
            dat_c[i+1] = main_data_q[i];
        end
    end

    // Skid slices offer a registered ready; single-entry slices chain ready combinationally.
    always_comb begin
        rdy_c         = '0;
        rdy_c[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (SKID != 0) begin
                rdy_c[i] = ready_q[i];
            end else begin
                rdy_c[i] = !main_valid_q[i] | rdy_c[i+1];
            end
        end
    end

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        up_fire      = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            up_fire = vld_c[i] & rdy_c[i];
            if (flush) begin
                main_valid_d[i] = 1'b0;
                skid_valid_d[i] = 1'b0;
            end else if (SKID != 0) begin
                if (!main_valid_q[i] || rdy_c[i+1]) begin
                    if (skid_valid_q[i]) begin
                        main_valid_d[i] = 1'b1;
                        main_data_d[i]  = skid_data_q[i];
                        skid_valid_d[i] = 1'b0;
                    end else begin
                        main_valid_d[i] = up_fire;
                        if (up_fire) begin
                            main_data_d[i] = dat_c[i];
                        end
                    end
                end else if (up_fire) begin
                    skid_valid_d[i] = 1'b1;
                    skid_data_d[i]  = dat_c[i];
                end
            end else begin
                if (up_fire) begin
                    main_valid_d[i] = 1'b1;
                    main_data_d[i]  = dat_c[i];
                end else if (rdy_c[i+1]) begin
                    main_valid_d[i] = 1'b0;
                end
            end
        end
        ready_d = ~skid_valid_d;
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign occ_d    = flush ? '0 : occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= '0;
            skid_valid_q <= '0;
            ready_q      <= '1;
            occ_q        <= '0;
            for (int i = 0; i < STAGES; i++) begin
                main_data_q[i] <= '0;
                skid_data_q[i] <= '0;
            end
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            occ_q        <= occ_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = rdy_c[0];
    assign out_valid = vld_c[STAGES];
    assign out_data  = dat_c[STAGES];
    assign occupancy = occ_q;
    assign busy      = (occ_q != '0);

endmodule

// File: tb/tb_pipe_chain.sv
// tb/tb_pipe_chain.sv - randomized and directed checks of pipe_chain over several parameter sets
module tb_pipe_chain;

    localparam int NCFG = 8;

    function automatic int cfg_dw(input int k);
        case (k)
            0: return 32;
            1: return 32;
            2: return 8;
            3: return 1;
            4: return 64;
            5: return 8;
            6: return 1;
            default: return 64;
        endcase
    endfunction

    function automatic int cfg_st(input int k);
        case (k)
            0: return 4;
            1: return 4;
            2: return 1;
            3: return 1;
            4: return 7;
            5: return 2;
            6: return 2;
            default: return 7;
        endcase
    endfunction

    function automatic int cfg_sk(input int k);
        return (k % 2 == 0) ? 1 : 0;
    endfunction

    typedef struct {
        logic [63:0] d;
        int          acc;
        int          del;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar K = 0; K < NCFG; K++) begin : g_cfg
        localparam int DW  = cfg_dw(K);
        localparam int ST  = cfg_st(K);
        localparam int SK  = cfg_sk(K);
        localparam int CAP = ST * ((SK != 0) ? 2 : 1);
        localparam int OW  = $clog2(CAP + 1);
        localparam logic [63:0] MSK = (DW == 64) ? '1 : ((64'd1 << DW) - 64'd1);

        logic          rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
        logic [DW-1:0] in_data, out_data;
        logic [OW-1:0] occupancy;

        ent_t        mq[$];
        ent_t        log_q[$];
        int          nidx = 0;
        bit          hold_v = 0;
        bit          post_flush = 0;
        logic [63:0] hold_d = '0;

        pipe_chain #(.DATA_WIDTH(DW), .STAGES(ST), .SKID(SK)) dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .occupancy (occupancy),
            .busy      (busy)
        );

        task automatic push(input logic [63:0] x);
            int          g;
            bit          f;
            logic [63:0] t;
            g = 0;
            f = 0;
            t = x;
            in_valid = 1'b1;
            in_data  = t[DW-1:0];
            while (!f && g < 500) begin
                @(negedge clk);
                f = in_ready;
                @(posedge clk);
                #1;
                g++;
            end
            in_valid = 1'b0;
            chk(f, $sformatf("c%0d push accepted", K), 64'(f), 64'd1);
        endtask

        task automatic wait_log(input int n);
            int g;
            g = 0;
            while (log_q.size() < n && g < 3000) begin
                @(posedge clk);
                g++;
            end
            #1;
            chk(log_q.size() >= n, $sformatf("c%0d drain count", K), 64'(log_q.size()), 64'(n));
        endtask

        // Reference: FIFO of accepted words; occupancy is its size, head is what must be presented.
        always @(negedge clk) begin : cmp
            ent_t e;
            nidx++;
            if (rst) begin
                chk(out_valid == 1'b0, $sformatf("c%0d rst out_valid", K), 64'(out_valid), 64'd0);
                chk(occupancy == '0, $sformatf("c%0d rst occupancy", K), 64'(occupancy), 64'd0);
                chk(busy == 1'b0, $sformatf("c%0d rst busy", K), 64'(busy), 64'd0);
                chk(in_ready == 1'b1, $sformatf("c%0d rst in_ready", K), 64'(in_ready), 64'd1);
                chk(out_data == '0, $sformatf("c%0d rst out_data", K), 64'(out_data), 64'd0);
                mq.delete();
                hold_v     = 0;
                post_flush = 0;
            end else begin
                chk(int'(occupancy) == mq.size(), $sformatf("c%0d occupancy", K), 64'(occupancy), 64'(mq.size()));
                chk(busy == (mq.size() != 0), $sformatf("c%0d busy", K), 64'(busy), 64'(mq.size() != 0));
                if (mq.size() == 0) begin
                    chk(!out_valid, $sformatf("c%0d out_valid while empty", K), 64'(out_valid), 64'd0);
                end else if (out_valid) begin
                    e = mq[0];
                    chk(64'(out_data) == e.d, $sformatf("c%0d head data", K), 64'(out_data), e.d);
                    chk(nidx - e.acc >= ST, $sformatf("c%0d latency floor", K), 64'(nidx - e.acc), 64'(ST));
                end
                if (hold_v) begin
                    chk(out_valid, $sformatf("c%0d stall valid", K), 64'(out_valid), 64'd1);
                    chk(64'(out_data) == hold_d, $sformatf("c%0d stall data", K), 64'(out_data), hold_d);
                end
                if (post_flush) begin
                    chk(in_ready, $sformatf("c%0d ready after flush", K), 64'(in_ready), 64'd1);
                end
                if (SK == 0) begin
                    chk(in_ready == (mq.size() < CAP || out_ready), $sformatf("c%0d in_ready", K),
                        64'(in_ready), 64'(mq.size() < CAP || out_ready));
                end else if (mq.size() == CAP) begin
                    chk(!in_ready, $sformatf("c%0d in_ready when full", K), 64'(in_ready), 64'd0);
                end
                hold_v     = out_valid && !out_ready && !flush;
                hold_d     = 64'(out_data);
                post_flush = flush;
                if (out_valid && out_ready && mq.size() > 0) begin
                    e     = mq[0];
                    e.del = nidx;
                    log_q.push_back(e);
                    void'(mq.pop_front());
                end
                if (flush) begin
                    mq.delete();
                end else if (in_valid && in_ready) begin
                    mq.push_back('{d: 64'(in_data), acc: nidx, del: 0});
                end
            end
        end

        initial begin : stim
            logic [63:0] v, cur;
            logic [63:0] expq[$];
            int          n, g, sent;
            bit          pend;

            rst       = 1'b1;
            flush     = 1'b0;
            in_valid  = 1'b1;
            v         = 64'hFF;
            in_data   = v[DW-1:0];
            out_ready = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst      = 1'b0;
            in_valid = 1'b0;

            // reset with data in flight: words must vanish
            n = (CAP < 2) ? 1 : 2;
            for (int i = 0; i < n; i++) push(64'hE1 + 64'(i));
            @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk(!out_valid, $sformatf("c%0d async rst out_valid", K), 64'(out_valid), 64'd0);
            chk(occupancy == '0, $sformatf("c%0d async rst occupancy", K), 64'(occupancy), 64'd0);
            chk(in_ready, $sformatf("c%0d async rst in_ready", K), 64'(in_ready), 64'd1);
            @(posedge clk);
            #1 rst = 1'b0;
            out_ready = 1'b1;
            repeat (ST + 3) @(posedge clk);
            #1;

            // streaming
            log_q.delete();
            for (int i = 0; i < 8; i++) push(64'hA1 + 64'(i));
            wait_log(8);
            chk(log_q.size() == 8, $sformatf("c%0d stream count", K), 64'(log_q.size()), 64'd8);
            for (int i = 0; i < log_q.size(); i++) begin
                chk(log_q[i].d == ((64'hA1 + 64'(i)) & MSK), $sformatf("c%0d stream data %0d", K, i),
                    log_q[i].d, (64'hA1 + 64'(i)) & MSK);
                if (i == 0) begin
                    chk(log_q[0].del - log_q[0].acc == ST, $sformatf("c%0d stream latency", K),
                        64'(log_q[0].del - log_q[0].acc), 64'(ST));
                end else begin
                    chk(log_q[i].del - log_q[i-1].del == 1, $sformatf("c%0d stream out gap %0d", K, i),
                        64'(log_q[i].del - log_q[i-1].del), 64'd1);
                    chk(log_q[i].acc - log_q[i-1].acc == 1, $sformatf("c%0d stream in gap %0d", K, i),
                        64'(log_q[i].acc - log_q[i-1].acc), 64'd1);
                end
            end

            // backpressure fill up to capacity
            @(posedge clk);
            #1;
            log_q.delete();
            out_ready = 1'b0;
            in_valid  = 1'b1;
            n = 0;
            g = 0;
            while (g < 100) begin
                v       = 64'hB0 + 64'(n);
                in_data = v[DW-1:0];
                @(negedge clk);
                if (!in_ready) break;
                n++;
                @(posedge clk);
                #1;
                g++;
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            chk(n == CAP, $sformatf("c%0d fill count", K), 64'(n), 64'(CAP));
            chk(int'(occupancy) == CAP, $sformatf("c%0d fill occupancy", K), 64'(occupancy), 64'(CAP));
            #1 out_ready = 1'b1;
            #1;
            chk(in_ready == (SK == 0), $sformatf("c%0d ready path from out_ready", K), 64'(in_ready), 64'(SK == 0));
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
            wait_log(CAP);
            chk(log_q.size() == CAP, $sformatf("c%0d fill drain count", K), 64'(log_q.size()), 64'(CAP));
            for (int i = 0; i < log_q.size(); i++) begin
                chk(log_q[i].d == ((64'hB0 + 64'(i)) & MSK), $sformatf("c%0d fill data %0d", K, i),
                    log_q[i].d, (64'hB0 + 64'(i)) & MSK);
            end

            // random valid / ready
            log_q.delete();
            pend = 0;
            sent = 0;
            g    = 0;
            cur  = '0;
            while (sent < 200 && g < 4000) begin
                @(posedge clk);
                #1;
                if (!pend && $urandom_range(1, 0) == 1) begin
                    pend = 1;
                    cur  = {$urandom, $urandom} & MSK;
                end
                in_valid  = pend;
                v         = cur;
                in_data   = v[DW-1:0];
                out_ready = ($urandom_range(1, 0) == 1);
                @(negedge clk);
                if (in_valid && in_ready) begin
                    expq.push_back(cur);
                    pend = 0;
                    sent++;
                end
                g++;
            end
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk(sent == 200, $sformatf("c%0d random sent", K), 64'(sent), 64'd200);
            wait_log(sent);
            chk(log_q.size() == expq.size(), $sformatf("c%0d random count", K), 64'(log_q.size()), 64'(expq.size()));
            for (int i = 0; i < log_q.size() && i < expq.size(); i++) begin
                chk(log_q[i].d == expq[i], $sformatf("c%0d random data %0d", K, i), log_q[i].d, expq[i]);
            end

            // flush with a concurrent input word
            @(posedge clk);
            #1;
            log_q.delete();
            out_ready = 1'b0;
            n = (CAP < 3) ? CAP : 3;
            for (int i = 0; i < n; i++) push(64'hC1 + 64'(i));
            flush    = 1'b1;
            in_valid = 1'b1;
            v        = 64'hC4;
            in_data  = v[DW-1:0];
            @(posedge clk);
            #1;
            flush    = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            chk(occupancy == '0, $sformatf("c%0d flush occupancy", K), 64'(occupancy), 64'd0);
            chk(!out_valid, $sformatf("c%0d flush out_valid", K), 64'(out_valid), 64'd0);
            @(posedge clk);
            #1 out_ready = 1'b1;
            push(64'hD1);
            wait_log(1);
            repeat (2 * ST + 4) @(posedge clk);
            #1;
            chk(log_q.size() == 1, $sformatf("c%0d post-flush count", K), 64'(log_q.size()), 64'd1);
            if (log_q.size() > 0) begin
                chk(log_q[0].d == (64'hD1 & MSK), $sformatf("c%0d post-flush data", K), log_q[0].d, 64'hD1 & MSK);
            end
            done_cnt++;
        end
    end

    initial begin : summary
        int g;
        g = 0;
        while (done_cnt < NCFG && g < 40000) begin
            @(posedge clk);
            g++;
        end
        if (done_cnt < NCFG) begin
            chk(1'b0, "global timeout", 64'(done_cnt), 64'(NCFG));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
Name: pipe_chain

Overview:
- Parametrised successor of the single-stage valid/ready pipeline register: a chain of STAGES register slices with end-to-end valid/ready handshake.
- Two slice styles by mode: bubble-collapsing single-entry slices, or full-throughput skid slices with registered ready. The skid style breaks the combinational ready path across long datapaths.
- Adds synchronous flush and an occupancy count.
- Sits between any producer/consumer pair in the datapath where timing needs retiming stages without losing throughput.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1).
- STAGES, 4, number of register slices (>=1).
- SKID, 1, slice style:
  - 1: each slice holds 2 entries (main + skid), and in_ready is a flop output.
  - 0: each slice holds 1 entry, and ready is combinational.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all contents.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  chain can accept this cycle.
- in_data  input  DATA_WIDTH  upstream payload.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_WIDTH  head payload.
- occupancy  output  $clog2(CAP+1)  valid entries held, where CAP = STAGES*(SKID?2:1).
- busy  output  1  occupancy != 0.

Behaviour:
- Transfers:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - All state changes occur on the rising edge of clk.
- Reset (async, rst=1):
  - All valid flags are cleared immediately and data registers are zeroed.
  - out_valid=0, out_data=0, occupancy=0, busy=0, in_ready=1.
  - No transfer is recorded while rst=1.
  - Reset mid-stream drops all held data without completing any transfer.
- SKID=0 slice:
  - Slice ready = !valid_q | next_ready.
  - On load, data_q takes the upstream data and valid_q is set.
  - When the downstream consumes and nothing loads, valid_q is cleared.
  - in_ready is combinational from out_ready through all slices.
- SKID=1 slice:
  - ready_q = !skid_valid, registered, with reset value 1.
  - If the main entry is valid, next_ready=0 and an upstream transfer occurs, the payload goes to skid and ready_q falls on the next edge.
  - When next_ready=1, the main entry takes skid (if valid) else upstream; skid_valid clears and ready_q rises on the next edge.
  - No combinational path from out_ready to in_ready.
- Latency:
  - With an empty chain and out_ready=1, data accepted at edge k appears on out_data with out_valid=1 after edge k+STAGES-1.
  - Each slice adds one cycle.
- Throughput: one transfer per cycle sustained in both modes while out_ready=1.
- Capacity:
  - With out_ready=0, the chain accepts exactly CAP entries, then in_ready=0.
  - SKID=1 drops in_ready one cycle after the tail skid fills; no entry is ever lost.
- Ordering: strict FIFO order, no duplication, no loss.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_valid hold constant.
- Producer rule: once in_valid is asserted, in_data holds until in_fire (checked by the bench, not by the RTL).
- Flush (synchronous, highest priority):
  - At an edge with flush=1, all valid and skid flags clear; occupancy=0 next cycle.
  - An out_fire at that edge counts as delivered.
  - An in_fire at that edge is discarded.
  - in_ready=1 the cycle after flush.
- Occupancy:
  - occupancy_next = occupancy + in_fire - out_fire, saturating-free because it is bounded by CAP.
  - Simultaneous in_fire and out_fire leaves the value unchanged.
  - Flush forces 0.
- Boundaries:
  - Full chain with out_ready=1 and in_valid=1: SKID=0 accepts in the same cycle; SKID=1 accepts from the cycle after ready_q recovers.
  - STAGES=1 must work in both modes.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, in_data=32'hFF → out_valid=0, occupancy=0, in_ready=1. Assert rst mid-stream after loading 32'hE1,32'hE2 → outputs clear asynchronously and neither word ever appears.
- Streaming: STAGES=4, out_ready=1, push 32'hA1..32'hA8 on consecutive cycles → first out_valid 3 cycles after the first accept. Then 8 consecutive out_fires in order with no gaps.
- Backpressure fill: out_ready=0, push 32'hB0.. until in_ready=0 → exactly 8 accepted (SKID=1) or 4 (SKID=0), occupancy=8/4. Release out_ready → drained in order, with out_data stable during the stall.
- Random stall: 200 random words, in_valid and out_ready each random at 50% → scoreboard matches all 200 in order. No combinational in_ready/out_ready dependency in SKID=1 (checked by toggling out_ready mid-cycle).
- Flush: load 32'hC1..32'hC3, assert flush for 1 cycle together with in_valid carrying 32'hC4 → occupancy=0 next cycle, C4 discarded. Then push 32'hD1 → D1 is the next output.
- Parameter sweep: STAGES in {1,2,7} × SKID in {0,1}, DATA_WIDTH in {1,8,64} → streaming and backpressure checks pass; latency = STAGES cycles.
